// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2,
        PASS   = 2'd3
    } state_t;

    function automatic int offset_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int lines, input int line_words);
        return 32 - $clog2(lines) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Line storage for the instruction cache: per-line valid bits, tag array and word data array.
// Reads are combinational so a hit can be answered in the LOOKUP cycle itself.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      wr_en,
    input  logic [index_bits(LINES)-1:0]              wr_index,
    input  logic [offset_bits(LINE_WORDS)-1:0]        wr_offset,
    input  logic [31:0]                               wr_data,
    input  logic                                      set_en,
    input  logic [tag_bits(LINES, LINE_WORDS)-1:0]    set_tag,
    input  logic                                      inv_en,
    input  logic [index_bits(LINES)-1:0]              inv_index,
    input  logic [index_bits(LINES)-1:0]              rd_index,
    input  logic [offset_bits(LINE_WORDS)-1:0]        rd_offset,
    output logic                                      rd_valid,
    output logic [tag_bits(LINES, LINE_WORDS)-1:0]    rd_tag,
    output logic [31:0]                               rd_data
);

    localparam int OB = offset_bits(LINE_WORDS);
    localparam int IB = index_bits(LINES);
    localparam int TB = tag_bits(LINES, LINE_WORDS);

    logic [LINES-1:0] valid_reg;
    logic [TB-1:0]    tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][LINE_WORDS];

    // Set and invalidate never coincide on the same line, so their order here is arbitrary.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_reg[gi] <= 1'b0;
            end else if (set_en && (wr_index == IB'(gi))) begin
                valid_reg[gi] <= 1'b1;
            end else if (inv_en && (inv_index == IB'(gi))) begin
                valid_reg[gi] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_mem[wr_index] <= set_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_index][wr_offset] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index][rd_offset];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; data loads/stores pass through uncached.
// Optional ICACHE_STORE_SNOOP_EN: pass-through stores invalidate a matching cached line.
module icache
    import icache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_valid,
    input  logic        core_instruction,
    input  logic [31:0] core_address,
    input  logic [31:0] core_write_data,
    input  logic [3:0]  core_write_strobe,
    output logic        core_ready,
    output logic [31:0] core_read_data,
    output logic        mem_valid,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_strobe,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data
);

    localparam int OB = offset_bits(LINE_WORDS);
    localparam int IB = index_bits(LINES);
    localparam int TB = tag_bits(LINES, LINE_WORDS);
    localparam logic [OB-1:0] LAST_COUNT = OB'(LINE_WORDS - 1);

    state_t         state_reg, state_next;
    logic [OB-1:0]  count_reg, count_next;
    logic [31:0]    addr_reg;
    logic [31:0]    wdata_reg;
    logic [3:0]     strobe_reg;

    logic [OB-1:0]  addr_offset;
    logic [IB-1:0]  addr_index;
    logic [TB-1:0]  addr_tag;

    logic           rd_valid;
    logic [TB-1:0]  rd_tag;
    logic [31:0]    rd_data;
    logic           tag_match;
    logic           hit;
    logic           last_word;

    logic           wr_en;
    logic           set_en;
    logic           inv_en;

    assign addr_offset = addr_reg[OB+1:2];
    assign addr_index  = addr_reg[IB+OB+1:OB+2];
    assign addr_tag    = addr_reg[31:IB+OB+2];
    assign tag_match   = (rd_tag == addr_tag);
    assign hit         = rd_valid && tag_match;
    assign last_word   = (count_reg == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg   <= '0;
            wdata_reg  <= '0;
            strobe_reg <= '0;
        end else if ((state_reg == IDLE) && core_valid) begin
            addr_reg   <= core_address;
            wdata_reg  <= core_write_data;
            strobe_reg <= core_write_strobe;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (core_valid) begin
                    state_next = core_instruction ? LOOKUP : PASS;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_next = IDLE;
                end else begin
                    state_next = FILL;
                    count_next = '0;
                end
            end
            FILL: begin
                if (mem_ready) begin
                    count_next = count_reg + 1'b1;
                    if (last_word) begin
                        state_next = LOOKUP;
                    end
                end
            end
            PASS: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        core_ready       = 1'b0;
        core_read_data   = '0;
        mem_valid        = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_strobe = '0;
        wr_en            = 1'b0;
        set_en           = 1'b0;
        inv_en           = 1'b0;
        case (state_reg)
            LOOKUP: begin
                core_ready     = hit;
                core_read_data = hit ? rd_data : 32'd0;
                inv_en         = !hit;
            end
            FILL: begin
                mem_valid   = 1'b1;
                mem_address = {addr_tag, addr_index, count_reg, 2'b00};
                wr_en       = mem_ready;
                set_en      = mem_ready && last_word;
            end
            PASS: begin
                mem_valid        = 1'b1;
                mem_address      = addr_reg;
                mem_write_data   = wdata_reg;
                mem_write_strobe = strobe_reg;
                core_ready       = mem_ready;
                core_read_data   = mem_read_data;
`ifdef ICACHE_STORE_SNOOP_EN
                // Valid is left alone when already clear, so only the tag needs to match.
                inv_en           = mem_ready && (strobe_reg != 4'b0000) && tag_match;
`endif
            end
            default: ;
        endcase
    end

    icache_line_store #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_store (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_index  (addr_index),
        .wr_offset (count_reg),
        .wr_data   (mem_read_data),
        .set_en    (set_en),
        .set_tag   (addr_tag),
        .inv_en    (inv_en),
        .inv_index (addr_index),
        .rd_index  (addr_index),
        .rd_offset (addr_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data)
    );

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: memory returns (address ^ 0xC0DE0000) after a programmable wait.
module tb_icache;

`ifdef ICACHE_STORE_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_valid = 1'b0;
    logic        core_instruction = 1'b0;
    logic [31:0] core_address = '0;
    logic [31:0] core_write_data = '0;
    logic [3:0]  core_write_strobe = '0;
    logic        core_ready;
    logic [31:0] core_read_data;
    logic        mem_valid;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_strobe;
    logic        mem_ready;
    logic [31:0] mem_read_data;

    int n_compared   = 0;
    int n_mismatched = 0;

    int mem_wait = 0;
    int wait_cnt = 0;
    int valid_cycles = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_strb[$];

    icache dut (
        .clk               (clk),
        .reset             (reset),
        .core_valid        (core_valid),
        .core_instruction  (core_instruction),
        .core_address      (core_address),
        .core_write_data   (core_write_data),
        .core_write_strobe (core_write_strobe),
        .core_ready        (core_ready),
        .core_read_data    (core_read_data),
        .mem_valid         (mem_valid),
        .mem_address       (mem_address),
        .mem_write_data    (mem_write_data),
        .mem_write_strobe  (mem_write_strobe),
        .mem_ready         (mem_ready),
        .mem_read_data     (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_ready     = mem_valid && (wait_cnt >= mem_wait);
    assign mem_read_data = mem_address ^ 32'hC0DE_0000;

    always @(posedge clk) begin
        if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
        if (mem_valid) valid_cycles <= valid_cycles + 1;
        if (mem_valid && mem_ready) begin
            log_addr.push_back(mem_address);
            log_wdata.push_back(mem_write_data);
            log_strb.push_back(mem_write_strobe);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one core request, returns data and latency (cycles after core_valid rises).
    task automatic do_req(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output int cycles);
        bit done = 1'b0;
        core_valid        = 1'b1;
        core_instruction  = instr;
        core_address      = addr;
        core_write_data   = wdata;
        core_write_strobe = strb;
        cycles = 0;
        rdata  = '0;
        while (!done && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
            if (core_ready) begin
                rdata = core_read_data;
                done  = 1'b1;
            end
        end
        if (!done) check_eq("req_timeout", 32'(cycles), 32'd0);
        @(posedge clk); #1;
        core_valid        = 1'b0;
        core_instruction  = 1'b0;
        core_write_strobe = '0;
        $display("req instr=%0b addr=0x%08h strb=%h -> data=0x%08h after %0d cycles",
                 instr, addr, strb, rdata, cycles);
    endtask

    task automatic check_fill(input string tag, input int start, input logic [31:0] base);
        check_eq({tag, "_count"}, 32'(log_addr.size() - start), 32'd4);
        for (int w = 0; w < 4; w++) begin
            if (start + w < log_addr.size()) begin
                check_eq({tag, "_addr"}, log_addr[start + w], base + 32'(4 * w));
                check_eq({tag, "_strb"}, 32'(log_strb[start + w]), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] rdata;
        int cycles;
        int n0;
        int v0;
        bit got2;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_core_ready", 32'(core_ready), 32'd0);
        check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rst_mem_strobe", 32'(mem_write_strobe), 32'd0);
        check_eq("rst_core_rdata", core_read_data, 32'd0);
        check_eq("rst_mem_addr", mem_address, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Cold miss on 0x100 refills the whole line.
        n0 = log_addr.size();
        do_req(1'b1, 32'h0000_0100, '0, 4'h0, rdata, cycles);
        check_eq("miss100_cycles", 32'(cycles), 32'd6);
        check_eq("miss100_data", rdata, 32'hC0DE_0100);
        check_fill("miss100_fill", n0, 32'h0000_0100);

        // Hit in the same line, no memory activity.
        v0 = valid_cycles;
        do_req(1'b1, 32'h0000_0108, '0, 4'h0, rdata, cycles);
        check_eq("hit108_cycles", 32'(cycles), 32'd1);
        check_eq("hit108_data", rdata, 32'hC0DE_0108);
        check_eq("hit108_mem_idle", 32'(valid_cycles - v0), 32'd0);

        // Conflict on index 0x10 evicts, then 0x100 misses again.
        n0 = log_addr.size();
        do_req(1'b1, 32'h0000_0500, '0, 4'h0, rdata, cycles);
        check_eq("miss500_cycles", 32'(cycles), 32'd6);
        check_eq("miss500_data", rdata, 32'hC0DE_0500);
        check_fill("miss500_fill", n0, 32'h0000_0500);
        n0 = log_addr.size();
        do_req(1'b1, 32'h0000_0100, '0, 4'h0, rdata, cycles);
        check_eq("remiss100_cycles", 32'(cycles), 32'd6);
        check_eq("remiss100_data", rdata, 32'hC0DE_0100);
        check_fill("remiss100_fill", n0, 32'h0000_0100);

        // Store passes straight through.
        n0 = log_addr.size();
        do_req(1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, rdata, cycles);
        check_eq("store_cycles", 32'(cycles), 32'd1);
        check_eq("store_count", 32'(log_addr.size() - n0), 32'd1);
        if (log_addr.size() > n0) begin
            check_eq("store_addr", log_addr[n0], 32'h0000_0104);
            check_eq("store_wdata", log_wdata[n0], 32'hDEAD_BEEF);
            check_eq("store_strb", 32'(log_strb[n0]), 32'hF);
        end

        // Fetch after store: refill with snooping, stale hit without.
        n0 = log_addr.size();
        do_req(1'b1, 32'h0000_0100, '0, 4'h0, rdata, cycles);
        check_eq("post_store_cycles", 32'(cycles), SNOOP ? 32'd6 : 32'd1);
        check_eq("post_store_data", rdata, 32'hC0DE_0100);
        check_eq("post_store_xfers", 32'(log_addr.size() - n0), SNOOP ? 32'd4 : 32'd0);

        // Uncached load with 3 wait states.
        mem_wait = 3;
        n0 = log_addr.size();
        do_req(1'b0, 32'h0000_2000, '0, 4'h0, rdata, cycles);
        check_eq("load_cycles", 32'(cycles), 32'd4);
        check_eq("load_data", rdata, 32'hC0DE_2000);
        check_eq("load_count", 32'(log_addr.size() - n0), 32'd1);
        if (log_addr.size() > n0) begin
            check_eq("load_addr", log_addr[n0], 32'h0000_2000);
            check_eq("load_strb", 32'(log_strb[n0]), 32'd0);
        end
        mem_wait = 0;

        // Cache contents unchanged by the load.
        v0 = valid_cycles;
        do_req(1'b1, 32'h0000_010C, '0, 4'h0, rdata, cycles);
        check_eq("hit10c_cycles", 32'(cycles), 32'd1);
        check_eq("hit10c_data", rdata, 32'hC0DE_010C);
        check_eq("hit10c_mem_idle", 32'(valid_cycles - v0), 32'd0);

        // Reset after two words of a fill abandons it.
        n0 = log_addr.size();
        core_valid       = 1'b1;
        core_instruction = 1'b1;
        core_address     = 32'h0000_0300;
        got2 = 1'b0;
        for (int c = 0; c < 20 && !got2; c++) begin
            @(posedge clk); #1;
            if (log_addr.size() >= n0 + 2) got2 = 1'b1;
        end
        check_eq("partial_two_words", 32'(got2), 32'd1);
        reset            = 1'b1;
        core_valid       = 1'b0;
        core_instruction = 1'b0;
        @(posedge clk); #1;
        check_eq("reset_fill_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("reset_fill_core_ready", 32'(core_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        n0 = log_addr.size();
        do_req(1'b1, 32'h0000_0300, '0, 4'h0, rdata, cycles);
        check_eq("miss300_cycles", 32'(cycles), 32'd6);
        check_eq("miss300_data", rdata, 32'hC0DE_0300);
        check_fill("miss300_fill", n0, 32'h0000_0300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
